// File: rtl/axi_rw_master_pkg.sv
// Shared AXI constants and FSM state encodings for the request-to-AXI4 master.
package axi_rw_master_pkg;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned OFF_W  = 3;

   localparam logic [1:0] BURST_INCR  = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] SIZE_1B = 3'd0;
   localparam logic [2:0] SIZE_2B = 3'd1;
   localparam logic [2:0] SIZE_4B = 3'd2;
   localparam logic [2:0] SIZE_8B = 3'd3;

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP, W_DONE} w_state_t;

   // Anything other than OKAY (EXOKAY included) is reported to the requester as an error.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_rw_master_strb_gen.sv
// Size + byte offset -> write strobe, and LSB-aligned data shifted into its byte lanes.
module axi_rw_master_strb_gen
   import axi_rw_master_pkg::*;
(
   input  logic [2:0]        size,
   input  logic [OFF_W-1:0]  offset,
   input  logic [DATA_W-1:0] data,
   output logic [STRB_W-1:0] strb_c,
   output logic [DATA_W-1:0] data_c
);

   logic [STRB_W-1:0] mask;

   // Byte mask for the access size, shifted to the offset; bytes past lane 7 are dropped.
   always_comb begin
      mask = '1;
      case (size)
         SIZE_1B: mask = 8'h01;
         SIZE_2B: mask = 8'h03;
         SIZE_4B: mask = 8'h0F;
         default: mask = 8'hFF;
      endcase
      strb_c = STRB_W'(mask << offset);
      data_c = data << {offset, 3'b000};
   end

endmodule

// File: rtl/axi_rw_master.sv
// Arbiter request/done interface to AXI4 master; independent read and write FSMs.
module axi_rw_master
   import axi_rw_master_pkg::*;
#(
   parameter int unsigned AXI_DATA_WIDTH = DATA_W,
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_ID_WIDTH   = 4,
   parameter int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
   input  logic                      clk,
   input  logic                      rst,
   // read request
   input  logic                      r_valid_i,
   input  logic [AXI_ADDR_WIDTH-1:0] r_addr_i,
   input  logic [7:0]                r_size_i,
   input  logic [7:0]                r_len_i,
   output logic                      r_ready_o,
   output logic [AXI_DATA_WIDTH-1:0] data_read_o,
   output logic                      r_err_o,
   // write request
   input  logic                      w_valid_i,
   input  logic [AXI_ADDR_WIDTH-1:0] w_addr_i,
   input  logic [AXI_DATA_WIDTH-1:0] rw_w_data_i,
   input  logic [7:0]                w_size_i,
   input  logic [7:0]                w_len_i,
   output logic                      w_ready_o,
   output logic                      w_err_o,
   // AR
   output logic                      axi_arvalid,
   output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
   output logic [AXI_ID_WIDTH-1:0]   axi_arid,
   output logic [7:0]                axi_arlen,
   output logic [2:0]                axi_arsize,
   output logic [1:0]                axi_arburst,
   input  logic                      axi_arready,
   // R
   output logic                      axi_rready,
   input  logic                      axi_rvalid,
   input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
   input  logic [1:0]                axi_rresp,
   input  logic                      axi_rlast,
   input  logic [AXI_ID_WIDTH-1:0]   axi_rid,
   // AW
   output logic                      axi_awvalid,
   output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
   output logic [AXI_ID_WIDTH-1:0]   axi_awid,
   output logic [7:0]                axi_awlen,
   output logic [2:0]                axi_awsize,
   output logic [1:0]                axi_awburst,
   input  logic                      axi_awready,
   // W
   output logic                      axi_wvalid,
   output logic [AXI_DATA_WIDTH-1:0] axi_wdata,
   output logic [AXI_STRB_WIDTH-1:0] axi_wstrb,
   output logic                      axi_wlast,
   input  logic                      axi_wready,
   // B
   output logic                      axi_bready,
   input  logic                      axi_bvalid,
   input  logic [1:0]                axi_bresp,
   input  logic [AXI_ID_WIDTH-1:0]   axi_bid
);

   r_state_t r_state, r_state_n;
   w_state_t w_state, w_state_n;

   logic r_hs, r_err_q, r_err_n;
   logic aw_hs, w_hs, awvalid_n, wvalid_n;
   logic [AXI_STRB_WIDTH-1:0] strb_c;
   logic [AXI_DATA_WIDTH-1:0] wdata_c;
   logic unused_inputs;

   // IDs, upper size bits and the write length carry no information for this master.
   assign unused_inputs = ^{axi_rid, axi_bid, r_size_i[7:3], w_size_i[7:3], w_len_i};

   assign axi_arid    = '0;
   assign axi_awid    = '0;
   assign axi_arburst = BURST_INCR;
   assign axi_awburst = BURST_INCR;
   assign axi_awlen   = 8'd0;
   assign axi_wlast   = 1'b1;

   // Write alignment from the raw request; results are captured when the request latches.
   axi_rw_master_strb_gen u_strb_gen (
      .size   (w_size_i[2:0]),
      .offset (w_addr_i[2:0]),
      .data   (rw_w_data_i),
      .strb_c (strb_c),
      .data_c (wdata_c)
   );

   // Read next state and running error accumulation.
   always_comb begin
      r_state_n = r_state;
      r_err_n   = r_err_q;
      r_hs      = axi_rvalid && axi_rready;
      case (r_state)
         R_IDLE: if (r_valid_i) begin
            r_state_n = R_ADDR;
            r_err_n   = 1'b0;
         end
         R_ADDR: if (axi_arvalid && axi_arready) r_state_n = R_DATA;
         R_DATA: if (r_hs) begin
            r_err_n = r_err_q | resp_is_err(axi_rresp);
            if (axi_rlast) r_state_n = R_DONE;
         end
         R_DONE:  r_state_n = R_IDLE;
         default: r_state_n = R_IDLE;
      endcase
   end

   // Read state, registered channel controls, request latch and beat capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= R_IDLE;
         r_err_q     <= 1'b0;
         axi_arvalid <= 1'b0;
         axi_rready  <= 1'b0;
         r_ready_o   <= 1'b0;
         r_err_o     <= 1'b0;
         data_read_o <= '0;
         axi_araddr  <= '0;
         axi_arlen   <= '0;
         axi_arsize  <= '0;
      end else begin
         r_state     <= r_state_n;
         r_err_q     <= r_err_n;
         axi_arvalid <= (r_state_n == R_ADDR);
         axi_rready  <= (r_state_n == R_DATA);
         r_ready_o   <= (r_state_n == R_DONE);
         r_err_o     <= (r_state_n == R_DONE) && r_err_n;
         if (r_state == R_IDLE && r_valid_i) begin
            axi_araddr <= r_addr_i;
            axi_arlen  <= r_len_i;
            axi_arsize <= r_size_i[2:0];
         end
         if (r_hs) data_read_o <= axi_rdata >> {axi_araddr[2:0], 3'b000};
      end
   end

   // Write next state; AW and W valids retire independently.
   always_comb begin
      w_state_n = w_state;
      awvalid_n = axi_awvalid;
      wvalid_n  = axi_wvalid;
      aw_hs     = axi_awvalid && axi_awready;
      w_hs      = axi_wvalid && axi_wready;
      case (w_state)
         W_IDLE: if (w_valid_i) begin
            w_state_n = W_XFER;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
         end
         W_XFER: begin
            if (aw_hs) awvalid_n = 1'b0;
            if (w_hs)  wvalid_n  = 1'b0;
            if (!awvalid_n && !wvalid_n) w_state_n = W_RESP;
         end
         W_RESP:  if (axi_bvalid && axi_bready) w_state_n = W_DONE;
         W_DONE:  w_state_n = W_IDLE;
         default: w_state_n = W_IDLE;
      endcase
   end

   // Write state, registered channel controls and aligned payload latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_state     <= W_IDLE;
         axi_awvalid <= 1'b0;
         axi_wvalid  <= 1'b0;
         axi_bready  <= 1'b0;
         w_ready_o   <= 1'b0;
         w_err_o     <= 1'b0;
         axi_awaddr  <= '0;
         axi_awsize  <= '0;
         axi_wdata   <= '0;
         axi_wstrb   <= '0;
      end else begin
         w_state     <= w_state_n;
         axi_awvalid <= awvalid_n;
         axi_wvalid  <= wvalid_n;
         axi_bready  <= (w_state_n == W_RESP);
         w_ready_o   <= (w_state_n == W_DONE);
         w_err_o     <= (w_state == W_RESP) && (w_state_n == W_DONE) && resp_is_err(axi_bresp);
         if (w_state == W_IDLE && w_valid_i) begin
            axi_awaddr <= w_addr_i;
            axi_awsize <= w_size_i[2:0];
            axi_wdata  <= wdata_c;
            axi_wstrb  <= strb_c;
         end
      end
   end

endmodule
